// File: rtl/rect_pulse_seq_if.sv
// rect_pulse_seq_if: control, configuration and DAC-code bundle for rect_pulse_seq.
// The master drives start/stop and the waveform configuration. The slave (the sequencer)
// returns the registered code stream and its status flags.
interface rect_pulse_seq_if #(
  parameter int WIDTH   = 12,
  parameter int CNT_W   = 16,
  parameter int BURST_W = 8
);
  logic               start;
  logic               stop;
  logic [WIDTH-1:0]   iv;
  logic [WIDTH-1:0]   pv;
  logic [CNT_W-1:0]   td;
  logic [CNT_W-1:0]   th;
  logic [CNT_W-1:0]   tl;
  logic [3:0]         tr_log2;
  logic [3:0]         tf_log2;
  logic [BURST_W-1:0] burst_len;
  logic [WIDTH-1:0]   dac_code;
  logic               dac_valid;
  logic               busy;
  logic               period_tick;

  modport master (
    output start, stop, iv, pv, td, th, tl, tr_log2, tf_log2, burst_len,
    input  dac_code, dac_valid, busy, period_tick
  );

  modport slave (
    input  start, stop, iv, pv, td, th, tl, tr_log2, tf_log2, burst_len,
    output dac_code, dac_valid, busy, period_tick
  );
endinterface

// File: rtl/rect_pulse_seq.sv
// rect_pulse_seq: clocked trapezoid pulse sequencer (delay, rise, high, fall, low, repeat).
// Ramps are 2^n cycles long, so each ramp step is an add and an arithmetic shift.
// Define RECT_SEQ_BURST_EN to build the period counter that ends a run after burst_len periods.
module rect_pulse_seq #(
  parameter int WIDTH   = 12,
  parameter int CNT_W   = 16,
  parameter int BURST_W = 8
) (
  input logic             clk,
  input logic             reset,
  rect_pulse_seq_if.slave bus
);

  typedef enum logic [2:0] {IDLE, DELAY, RISE, HIGH, FALL, LOW} state_t;

  // The accumulator must hold delta times the longest ramp (2^15 cycles).
  localparam int ACC_W = WIDTH + 17;

  state_t                  state, nxt_state;
  logic [CNT_W-1:0]        cnt, nxt_cnt;
  logic signed [ACC_W-1:0] acc, nxt_acc;
  logic [WIDTH-1:0]        code_r, nxt_code;
  logic                    tick_r, nxt_tick;
  logic                    busy_r;
  logic                    stop_pend;

  logic [WIDTH-1:0]        iv_s, pv_s;
  logic [CNT_W-1:0]        td_s, th_s, tl_s;
  logic [3:0]              tr_s, tf_s;

  // While IDLE the live inputs are used, so the first code can leave on the start edge.
  logic [WIDTH-1:0]        cur_iv, cur_pv;
  logic [CNT_W-1:0]        cur_th, cur_tl;
  logic [3:0]              cur_tr, cur_tf;
  logic signed [WIDTH:0]   delta;
  logic signed [ACC_W-1:0] delta_x;
  logic                    period_last, go_rise, go_fall, end_seq, burst_done;

  assign cur_iv = (state == IDLE) ? bus.iv      : iv_s;
  assign cur_pv = (state == IDLE) ? bus.pv      : pv_s;
  assign cur_th = (state == IDLE) ? bus.th      : th_s;
  assign cur_tl = (state == IDLE) ? bus.tl      : tl_s;
  assign cur_tr = (state == IDLE) ? bus.tr_log2 : tr_s;
  assign cur_tf = (state == IDLE) ? bus.tf_log2 : tf_s;

  assign delta   = $signed({1'b0, cur_pv}) - $signed({1'b0, cur_iv});
  assign delta_x = {{(ACC_W-WIDTH-1){delta[WIDTH]}}, delta};

  function automatic logic [CNT_W-1:0] ramp_last(input logic [3:0] sh);
    return (CNT_W'(1) << sh) - CNT_W'(1);
  endfunction

  // base + acc/2^sh with floor rounding; always lands between iv and pv, so it fits WIDTH.
  function automatic logic [WIDTH-1:0] ramp_code(input logic [WIDTH-1:0] base,
                                                 input logic signed [ACC_W-1:0] a,
                                                 input logic [3:0] sh);
    logic signed [ACC_W-1:0] sum;
    sum = $signed({{(ACC_W-WIDTH){1'b0}}, base}) + (a >>> sh);
    return sum[WIDTH-1:0];
  endfunction

`ifdef RECT_SEQ_BURST_EN
  logic [BURST_W-1:0] burst_s, per_cnt;
  assign burst_done = (burst_s != '0) && (BURST_W'(per_cnt + 1'b1) == burst_s);
`else
  logic unused_burst;
  assign unused_burst = ^bus.burst_len;
  assign burst_done   = 1'b0;
`endif

  assign end_seq = stop_pend | bus.stop | burst_done;

  // Next-state, counter, accumulator and code for the registered outputs.
  always_comb begin
    nxt_state   = state;
    nxt_cnt     = cnt;
    nxt_acc     = acc;
    nxt_code    = code_r;
    period_last = 1'b0;
    go_rise     = 1'b0;
    go_fall     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.td != '0) begin
            nxt_state = DELAY;
            nxt_cnt   = bus.td - CNT_W'(1);
            nxt_code  = bus.iv;
          end else begin
            go_rise = 1'b1;
          end
        end
      end
      DELAY: begin
        if (cnt == '0) go_rise = 1'b1;
        else           nxt_cnt = cnt - CNT_W'(1);
      end
      RISE: begin
        if (cnt == '0) begin
          if (cur_th != '0) begin
            nxt_state = HIGH;
            nxt_cnt   = cur_th - CNT_W'(1);
            nxt_code  = cur_pv;
          end else begin
            go_fall = 1'b1;
          end
        end else begin
          nxt_cnt  = cnt - CNT_W'(1);
          nxt_acc  = acc + delta_x;
          nxt_code = ramp_code(cur_iv, acc + delta_x, cur_tr);
        end
      end
      HIGH: begin
        if (cnt == '0) go_fall = 1'b1;
        else           nxt_cnt = cnt - CNT_W'(1);
      end
      FALL: begin
        if (cnt == '0) begin
          if (cur_tl != '0) begin
            nxt_state = LOW;
            nxt_cnt   = cur_tl - CNT_W'(1);
            nxt_code  = cur_iv;
          end else begin
            period_last = 1'b1;
          end
        end else begin
          nxt_cnt  = cnt - CNT_W'(1);
          nxt_acc  = acc - delta_x;
          nxt_code = ramp_code(cur_pv, acc - delta_x, cur_tf);
        end
      end
      LOW: begin
        if (cnt == '0) period_last = 1'b1;
        else           nxt_cnt = cnt - CNT_W'(1);
      end
      default: nxt_state = IDLE;
    endcase

    if (period_last) begin
      if (end_seq) begin
        nxt_state = IDLE;
        nxt_cnt   = '0;
        nxt_acc   = '0;
        nxt_code  = cur_iv;
      end else begin
        go_rise = 1'b1;
      end
    end
    if (go_rise) begin
      nxt_state = RISE;
      nxt_cnt   = ramp_last(cur_tr);
      nxt_acc   = delta_x;
      nxt_code  = ramp_code(cur_iv, delta_x, cur_tr);
    end
    if (go_fall) begin
      nxt_state = FALL;
      nxt_cnt   = ramp_last(cur_tf);
      nxt_acc   = -delta_x;
      nxt_code  = ramp_code(cur_pv, -delta_x, cur_tf);
    end

    // The tick marks the final cycle of a period: the last LOW cycle, or the last FALL cycle when tl = 0.
    nxt_tick = (nxt_cnt == '0) &&
               ((nxt_state == LOW) || ((nxt_state == FALL) && (cur_tl == '0)));
  end

  // Sequencer state, shadow configuration and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      code_r    <= '0;
      tick_r    <= 1'b0;
      busy_r    <= 1'b0;
      stop_pend <= 1'b0;
      iv_s      <= '0;
      pv_s      <= '0;
      td_s      <= '0;
      th_s      <= '0;
      tl_s      <= '0;
      tr_s      <= '0;
      tf_s      <= '0;
`ifdef RECT_SEQ_BURST_EN
      burst_s   <= '0;
      per_cnt   <= '0;
`endif
    end else begin
      state  <= nxt_state;
      cnt    <= nxt_cnt;
      acc    <= nxt_acc;
      code_r <= nxt_code;
      tick_r <= nxt_tick;
      busy_r <= (nxt_state != IDLE);
      if (nxt_state == IDLE) stop_pend <= 1'b0;
      else if (bus.stop)     stop_pend <= 1'b1;
      if (state == IDLE && bus.start) begin
        iv_s <= bus.iv;
        pv_s <= bus.pv;
        td_s <= bus.td;
        th_s <= bus.th;
        tl_s <= bus.tl;
        tr_s <= bus.tr_log2;
        tf_s <= bus.tf_log2;
      end
`ifdef RECT_SEQ_BURST_EN
      if (state == IDLE && bus.start) burst_s <= bus.burst_len;
      if (state == IDLE)              per_cnt <= '0;
      else if (tick_r)                per_cnt <= per_cnt + 1'b1;
`endif
    end
  end

  assign bus.dac_code    = code_r;
  assign bus.dac_valid   = busy_r;
  assign bus.busy        = busy_r;
  assign bus.period_tick = tick_r;

endmodule

// File: tb/tb_rect_pulse_seq.sv
// tb_rect_pulse_seq: directed and randomized runs of rect_pulse_seq against a waveform model
// that lists the expected code and tick of every busy cycle from the shape parameters.
module tb_rect_pulse_seq;
  localparam int WIDTH   = 12;
  localparam int CNT_W   = 16;
  localparam int BURST_W = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rect_pulse_seq_if #(.WIDTH(WIDTH), .CNT_W(CNT_W), .BURST_W(BURST_W)) bus ();

  rect_pulse_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W), .BURST_W(BURST_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  int q_code[$];
  int q_tick[$];
  int q_per[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic int fdiv(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  // Expected busy-cycle stream for np periods of the given shape.
  task automatic build(input int iv, input int pv, input int td, input int th, input int tl,
                       input int tr, input int tf, input int np);
    int r, f;
    q_code.delete(); q_tick.delete(); q_per.delete();
    r = 1 << tr;
    f = 1 << tf;
    for (int p = 1; p <= np; p++) begin
      if (p == 1)
        for (int k = 0; k < td; k++) begin q_code.push_back(iv); q_tick.push_back(0); q_per.push_back(p); end
      for (int k = 1; k <= r; k++) begin
        q_code.push_back(iv + fdiv(k * (pv - iv), r)); q_tick.push_back(0); q_per.push_back(p);
      end
      for (int k = 0; k < th; k++) begin q_code.push_back(pv); q_tick.push_back(0); q_per.push_back(p); end
      for (int k = 1; k <= f; k++) begin
        q_code.push_back(pv + fdiv(k * (iv - pv), f)); q_tick.push_back(0); q_per.push_back(p);
      end
      for (int k = 0; k < tl; k++) begin q_code.push_back(iv); q_tick.push_back(0); q_per.push_back(p); end
      q_tick[q_tick.size()-1] = 1;
    end
  endtask

  task automatic drive_cfg(input int iv, input int pv, input int td, input int th, input int tl,
                           input int tr, input int tf, input int burst);
    bus.iv        = WIDTH'(iv);
    bus.pv        = WIDTH'(pv);
    bus.td        = CNT_W'(td);
    bus.th        = CNT_W'(th);
    bus.tl        = CNT_W'(tl);
    bus.tr_log2   = 4'(tr);
    bus.tf_log2   = 4'(tf);
    bus.burst_len = BURST_W'(burst);
  endtask

  // mode 0: stop somewhere in period np; mode 1: stop together with start; mode 2: no stop (burst ends it).
  // Every run also pulses start with scrambled config while busy, which must be ignored.
  task automatic run(input int iv, input int pv, input int td, input int th, input int tl,
                     input int tr, input int tf, input int np, input int mode, input int burst);
    int stop_idx, pulse_idx, n;
    int cand[$];
    drive_cfg(iv, pv, td, th, tl, tr, tf, burst);
    bus.start = 1'b1;
    bus.stop  = (mode == 1);
    build(iv, pv, td, th, tl, tr, tf, np);
    n = q_code.size();
    for (int i = 0; i < n; i++) if (q_per[i] == np) cand.push_back(i);
    stop_idx  = cand[$urandom_range(0, cand.size() - 1)];
    pulse_idx = $urandom_range(0, n - 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      chk("dac_code", 32'(bus.dac_code), 32'(q_code[i]));
      chk("period_tick", 32'(bus.period_tick), 32'(q_tick[i]));
      chk("busy", 32'(bus.busy), 32'd1);
      chk("dac_valid", 32'(bus.dac_valid), 32'd1);
      if (mode == 0 && i == stop_idx) bus.stop = 1'b1;
      if (i == pulse_idx) begin
        bus.start   = 1'b1;
        bus.iv      = WIDTH'($urandom);
        bus.pv      = WIDTH'($urandom);
        bus.td      = CNT_W'($urandom_range(0, 3));
        bus.th      = CNT_W'($urandom_range(0, 3));
        bus.tl      = CNT_W'($urandom_range(0, 3));
        bus.tr_log2 = 4'($urandom_range(0, 3));
        bus.tf_log2 = 4'($urandom_range(0, 3));
      end
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("idle_valid", 32'(bus.dac_valid), 32'd0);
    chk("idle_tick", 32'(bus.period_tick), 32'd0);
    chk("idle_code", 32'(bus.dac_code), 32'(iv));
  endtask

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    drive_cfg(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_code", 32'(bus.dac_code), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_valid", 32'(bus.dac_valid), 32'd0);
    chk("rst_tick", 32'(bus.period_tick), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_rel_busy", 32'(bus.busy), 32'd0);

    // Reference waveform: delay, 4-step rise, plateau, 2-step fall, one low cycle.
    run(12'h100, 12'h900, 3, 2, 1, 2, 1, 1, 0, 0);
    // Minimal period: 1-cycle rise and fall, alternating codes, tick every second cycle.
    run(12'hA00, 12'h200, 0, 0, 0, 0, 0, 5, 0, 0);
    // start and stop together give exactly one period.
    run(12'h050, 12'hC40, 2, 1, 2, 1, 2, 1, 1, 0);
    // Full-scale swing with pv below iv.
    run(12'hFFF, 12'h000, 1, 1, 0, 3, 3, 2, 0, 0);

    // Reset asynchronously while HIGH at full scale.
    drive_cfg(12'h100, 12'hFFF, 0, 6, 2, 1, 0, 0);
    bus.start = 1'b1;
    build(12'h100, 12'hFFF, 0, 6, 2, 1, 0, 1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      chk("pre_rst_code", 32'(bus.dac_code), 32'(q_code[i]));
    end
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_code", 32'(bus.dac_code), 32'd0);
    chk("async_rst_busy", 32'(bus.busy), 32'd0);
    chk("async_rst_valid", 32'(bus.dac_valid), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("post_rst_code", 32'(bus.dac_code), 32'd0);
      chk("post_rst_busy", 32'(bus.busy), 32'd0);
      chk("post_rst_tick", 32'(bus.period_tick), 32'd0);
    end

    // Randomized shapes, period counts and stop placement.
    for (int t = 0; t < 20; t++) begin
      int np;
      np = $urandom_range(1, 3);
      run($urandom_range(0, 4095), $urandom_range(0, 4095), $urandom_range(0, 5),
          $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 3),
          np, 0, np + $urandom_range(1, 5));
    end

`ifdef RECT_SEQ_BURST_EN
    run(12'h300, 12'h700, 2, 1, 1, 1, 1, 3, 2, 3);
    run(12'h7FF, 12'h001, 0, 0, 1, 0, 1, 10, 0, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
